// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the dual-port clearable RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  // Bits needed to count 0..depth-1, never less than one.
  function automatic int cnt_width(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks cnt over 0..DEPTH-1 after reset or a clr request,
// driving one clear write per cycle while busy is high.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             busy,
  output logic             clr_we,
  output logic [CNT_W-1:0] clr_addr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        // Terminal compare against DEPTH-1 keeps odd depths off unused words.
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // The reset cycle itself must leave the array untouched.
  assign clr_we   = (state == CLEAR) && !rst;
  assign clr_addr = cnt;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port synchronous RAM with sequential clear sweep and registered read.
// Define RAM_BYPASS_EN for write-first same-address behaviour (default read-first).
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int                DEPTH   = 32,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy
);

  localparam int            CNT_W   = cnt_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              seq_we;
  logic [CNT_W-1:0]  seq_addr;
  logic              user_ok;
  logic              wr_hit;
  logic              rd_hit;
  logic              rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  ram_clr_seq #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (seq_we),
    .clr_addr (seq_addr)
  );

  // User accesses only in IDLE, and a clr request drops any access beside it.
  assign user_ok = !rst && !busy && !clr;
  assign wr_hit  = {1'b0, waddr} < DEPTH_X;
  assign rd_hit  = {1'b0, raddr} < DEPTH_X;
  assign rd_acc  = user_ok && rd_en;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = din;
    if (seq_we) begin
      mem_we    = 1'b1;
      mem_waddr = ADDR_W'(seq_addr);
      mem_wdata = CLR_VAL;
    end else if (user_ok && wr_en && wr_hit) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) begin
        if (!rd_hit) begin
          dout <= '0;
`ifdef RAM_BYPASS_EN
        end else if (wr_en && wr_hit && (waddr == raddr)) begin
          dout <= din;
`endif
        end else begin
          dout <= mem[raddr];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: DEPTH=32 instance driven through a scoreboard,
// plus a DEPTH=20 instance for out-of-range addressing.
module tb_ram_dp_clr;

  typedef struct {
    logic       we;
    logic [4:0] wa;
    logic [7:0] d;
    logic       re;
    logic [4:0] ra;
    logic       expValid;
    logic [7:0] expData;
  } vec_t;

`ifdef RAM_BYPASS_EN
  localparam logic [7:0] SAME_A = 8'h22;
  localparam logic [7:0] SAME_B = 8'h77;
`else
  localparam logic [7:0] SAME_A = 8'h11;
  localparam logic [7:0] SAME_B = 8'h3C;
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr, wr_en, rd_en;
  logic [4:0] waddr, raddr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid, busy;

  logic       b_rst, b_clr, b_wr_en, b_rd_en;
  logic [4:0] b_waddr, b_raddr;
  logic [7:0] b_din;
  logic [7:0] b_dout;
  logic       b_dout_valid, b_busy;

  ram_dp_clr #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .CLR_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .waddr(waddr), .din(din),
    .rd_en(rd_en), .raddr(raddr), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  ram_dp_clr #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .CLR_VAL(8'h3C)) dut20 (
    .clk(clk), .rst(b_rst), .clr(b_clr), .wr_en(b_wr_en), .waddr(b_waddr), .din(b_din),
    .rd_en(b_rd_en), .raddr(b_raddr), .dout(b_dout), .dout_valid(b_dout_valid), .busy(b_busy)
  );

  int         checks;
  int         failures;
  logic [7:0] sbq[$];
  logic [7:0] expDout;
  logic       readPending;
  vec_t       vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [7:0] e;
    check("dout_valid", 32'(dout_valid), 32'(readPending));
    if (dout_valid) begin
      check("sb_depth", 32'(sbq.size()), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("rd_data", 32'(dout), 32'(e));
        expDout = e;
      end
    end else begin
      check("dout_hold", 32'(dout), 32'(expDout));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic we,
                               input logic [4:0] wa, input logic [7:0] d,
                               input logic re, input logic [4:0] ra,
                               input logic expAcc, input logic [7:0] expData);
    rst = r; clr = c; wr_en = we; waddr = wa; din = d; rd_en = re; raddr = ra;
    if (r) begin
      sbq.delete();
      expDout = 8'h00;
    end
    readPending = re && expAcc && !r;
    if (readPending) sbq.push_back(expData);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, a, 1'b1, e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, a, d, 1'b0, 5'd0, 1'b0, 8'h00);
  endtask

  // Counts cycles until busy drops; with poke, hammers address 0 with ignored accesses.
  task automatic countBusy(input logic poke, output int n);
    n = 0;
    do begin
      if (poke) applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 8'hFF, 1'b1, 5'd0, 1'b0, 8'h00);
      else idle();
      n++;
    end while (busy && n < 200);
  endtask

  task automatic stepB(input logic we, input logic [4:0] wa, input logic [7:0] d,
                       input logic re, input logic [4:0] ra);
    b_wr_en = we; b_waddr = wa; b_din = d; b_rd_en = re; b_raddr = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; expDout = 8'h00; readPending = 1'b0;
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; waddr = '0; raddr = '0; din = '0;
    b_rst = 1'b1; b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_waddr = '0; b_raddr = '0; b_din = '0;

    vecs[0] = '{1'b1, 5'd7,  8'h11, 1'b0, 5'd0,  1'b0, 8'h00};
    vecs[1] = '{1'b1, 5'd7,  8'h22, 1'b1, 5'd7,  1'b1, SAME_A};
    vecs[2] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd7,  1'b1, 8'h22};
    vecs[3] = '{1'b1, 5'd3,  8'h33, 1'b1, 5'd9,  1'b1, 8'h09};
    vecs[4] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd3,  1'b1, 8'h33};
    vecs[5] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd9,  1'b1, 8'h09};
    vecs[6] = '{1'b1, 5'd31, 8'hC3, 1'b1, 5'd30, 1'b1, 8'h1E};
    vecs[7] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd31, 1'b1, 8'hC3};

    $display("[TB] reset and initial clear sweep");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00);
    check("busy_reset", 32'(busy), 32'd1);
    countBusy(1'b0, n);
    check("busy_len_reset", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'hA5);

    $display("[TB] write then read all words");
    for (int i = 0; i < 32; i++) wr(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 8'(i));
      idle();
    end

    $display("[TB] same-cycle read/write vectors");
    foreach (vecs[i])
      applyStimulus(1'b0, 1'b0, vecs[i].we, vecs[i].wa, vecs[i].d,
                    vecs[i].re, vecs[i].ra, vecs[i].expValid, vecs[i].expData);

    $display("[TB] clr request with colliding access");
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd4, 8'hEE, 1'b1, 5'd4, 1'b0, 8'h00);
    countBusy(1'b1, n);
    check("busy_len_clr", 32'(n), 32'd32);
    rd(5'd4, 8'hA5);
    rd(5'd0, 8'hA5);
    rd(5'd7, 8'hA5);

    $display("[TB] reset mid-sweep");
    for (int i = 0; i < 32; i++) wr(5'(i), 8'h5A);
    rd(5'd12, 8'h5A);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("busy_sweep", 32'(busy), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00);
    check("busy_rst_mid", 32'(busy), 32'd1);
    countBusy(1'b0, n);
    check("busy_len_restart", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'hA5);

    $display("[TB] DEPTH=20 instance");
    stepB(1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    b_rst = 1'b0;
    n = 0;
    do begin
      stepB(1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
      n++;
    end while (b_busy && n < 200);
    check("b_busy_len", 32'(n), 32'd20);
    stepB(1'b1, 5'd25, 8'hFF, 1'b0, 5'd0);
    stepB(1'b0, 5'd0, 8'h00, 1'b1, 5'd25);
    check("b_oor_valid", 32'(b_dout_valid), 32'd1);
    check("b_oor_data", 32'(b_dout), 32'd0);
    stepB(1'b0, 5'd0, 8'h00, 1'b1, 5'd5);
    check("b_addr5_valid", 32'(b_dout_valid), 32'd1);
    check("b_addr5_data", 32'(b_dout), 32'h3C);
    stepB(1'b1, 5'd19, 8'h77, 1'b1, 5'd19);
    check("b_same_data", 32'(b_dout), 32'(SAME_B));
    stepB(1'b0, 5'd0, 8'h00, 1'b1, 5'd19);
    check("b_last_data", 32'(b_dout), 32'h77);
    stepB(1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    check("b_idle_valid", 32'(b_dout_valid), 32'd0);
    check("b_idle_hold", 32'(b_dout), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
# ram_dp_clr

Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on one clock. It replaces the fixed 32×8 single-port `wr_re` RAM in the memory library. The one-cycle whole-array reset is replaced by a sequential clear sweep, which synthesises to real block RAM at any depth. The block adds simultaneous read/write, a registered `dout_valid`, a software clear request, and optional write-to-read forwarding.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 5, address width
- DEPTH, 32, number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W
- CLR_VAL, 0, DATA_W-wide value written to every word by a clear sweep

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- clr  in  1  clear request; single-cycle pulse, honoured only when idle
- wr_en  in  1  write strobe
- waddr  in  ADDR_W  write address
- din  in  DATA_W  write data
- rd_en  in  1  read strobe
- raddr  in  ADDR_W  read address
- dout  out  DATA_W  registered read data; holds its value between reads
- dout_valid  out  1  high for exactly one cycle per accepted read
- busy  out  1  high while the clear sweep runs; accesses are ignored while it is high

## Operation
- Two states, CLEAR and IDLE.
- rst high: state=CLEAR, cnt=0, dout=0, dout_valid=0, busy=1. Memory contents are not touched in the reset cycle.
- CLEAR state, rst low:
  - each cycle writes mem[cnt]=CLR_VAL and increments cnt
  - after the write with cnt==DEPTH-1, the state moves to IDLE and busy falls
- In CLEAR, wr_en and rd_en are ignored: no write, no dout_valid, dout holds. clr is ignored.
- In IDLE, clr=1 gives state=CLEAR, cnt=0, busy=1 next cycle. A wr_en or rd_en in the same cycle as clr is dropped; clr wins.
- IDLE write: when wr_en=1 and waddr<DEPTH, mem[waddr]=din. A write with waddr≥DEPTH is silently dropped.
- IDLE read: when rd_en=1, dout_valid=1 next cycle.
  - raddr<DEPTH: dout=mem[raddr]
  - raddr≥DEPTH: dout=0
- Simultaneous write and read to the same in-range address: the result depends on the forwarding option (see Configuration).
- Simultaneous write and read to different addresses: the two accesses are fully independent.
- rst asserted mid-sweep: the sweep restarts from cnt=0 after rst falls. Words already cleared stay cleared.
- rst asserted during normal operation: memory contents are retained until the sweep overwrites them. dout is 0 immediately after reset.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge N gives dout and dout_valid at edge N+1.
- Write is visible to a read issued at the next edge (edge N+1 or later) without any forwarding.
- busy stays high for exactly DEPTH cycles after the first posedge with rst low, or after the clr edge.
- The first access is accepted in the cycle busy is low.
- cnt is a ceil(log2(DEPTH))-bit counter, minimum 1 bit. The terminal compare is against DEPTH-1, so non-power-of-two depths never wrap into unused words.

## Configuration
- Macro RAM_BYPASS_EN.
- Defined: a same-cycle, same-address, in-range write and read returns the new din on dout (write-first).
- Undefined: the same case returns the old memory content (read-first).
- Both builds give identical results for every other access pattern.

## Structure
- Shared package ram_pkg holds:
  - the state enum (CLEAR, IDLE)
  - default width constants for DATA_W and ADDR_W
  - a clog2-style function for sizing cnt
- Natural sub-module is ram_clr_seq. It contains the state register, cnt and busy, and outputs the clear write enable and clear address.
- The top level muxes the write port between ram_clr_seq and the user port, and holds the array and read register.

## Test plan
- Reset, DEPTH=32, CLR_VAL=8'hA5: rst high for 2 cycles, then low → busy high for exactly 32 cycles; reads of all 32 addresses afterwards return 8'hA5.
- Write 0x00..0x1F to addresses 0..31, then read 0..31 → dout equals written data one cycle after each rd_en, with dout_valid pulsing once per read and dout holding between reads.
- Same-cycle wr_en/rd_en to address 7, old value 8'h11, din 8'h22 → dout is 8'h11 without RAM_BYPASS_EN and 8'h22 with it. A parallel write to 3 and read from 9 are unaffected.
- DEPTH=20, ADDR_W=5: write 8'hFF to address 25, then read 25 → write dropped, dout=0 with dout_valid=1, address 5 unchanged; busy lasts 20 cycles.
- clr pulse together with wr_en to address 4 → write dropped; busy for DEPTH cycles; wr_en/rd_en issued during busy produce no write and no dout_valid.
- rst pulse at cnt=10 mid-sweep → cnt restarts at 0; busy lasts a full DEPTH cycles after rst falls; final contents are all CLR_VAL.
